// File: rtl/jvm_mem_arbiter.sv
// rtl/jvm_mem_arbiter.sv - Fetch/execute arbiter for the shared JVM bytecode/data memory port.
// Optional ARB_ROUND_ROBIN_EN: on a tie the requester not served last wins instead of execute.
module jvm_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              fetch_lock,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              exec_req,
    input  logic              exec_we,
    input  logic              exec_lock,
    input  logic [ADDR_W-1:0] exec_addr,
    input  logic [DATA_W-1:0] exec_wdata,
    output logic              exec_gnt,
    output logic              exec_valid,
    output logic [DATA_W-1:0] exec_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_F = 2'b01,
        OWN_E = 2'b10
    } state_t;

    localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_exec_q, last_exec_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             exec_valid_q, exec_valid_d;
    logic             tenure_end;
    logic             tie_to_exec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            last_exec_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            exec_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_exec_q   <= last_exec_d;
            fetch_valid_q <= fetch_valid_d;
            exec_valid_q  <= exec_valid_d;
        end
    end

    always_comb begin
        fetch_gnt = (state_q == OWN_F) && fetch_req;
        exec_gnt  = (state_q == OWN_E) && exec_req;

        // A tenure survives only a locked beat below the limit; anything else re-arbitrates.
        case (state_q)
            OWN_F:   tenure_end = !fetch_req || !fetch_lock || (cnt_q == CNT_LAST);
            OWN_E:   tenure_end = !exec_req || !exec_lock || (cnt_q == CNT_LAST);
            default: tenure_end = 1'b1;
        endcase

`ifdef ARB_ROUND_ROBIN_EN
        tie_to_exec = !last_exec_q;
`else
        tie_to_exec = 1'b1;
`endif

        state_d     = state_q;
        cnt_d       = cnt_q;
        last_exec_d = last_exec_q;
        if (tenure_end) begin
            cnt_d = '0;
            if (exec_req && (!fetch_req || tie_to_exec)) begin
                state_d     = OWN_E;
                last_exec_d = 1'b1;
            end else if (fetch_req) begin
                state_d     = OWN_F;
                last_exec_d = 1'b0;
            end else begin
                state_d = IDLE;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        fetch_valid_d = fetch_gnt;
        exec_valid_d  = exec_gnt && !exec_we;

        mem_en    = fetch_gnt || exec_gnt;
        mem_we    = exec_gnt && exec_we;
        mem_addr  = fetch_gnt ? fetch_addr : (exec_gnt ? exec_addr : '0);
        mem_wdata = exec_gnt ? exec_wdata : '0;

        fetch_valid = fetch_valid_q;
        exec_valid  = exec_valid_q;
        fetch_data  = fetch_valid_q ? mem_rdata : '0;
        exec_rdata  = exec_valid_q ? mem_rdata : '0;
        owner       = state_q;
    end

endmodule
